// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: memory-side request/acknowledge bus of the unified port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, data has priority.
// Optional one-entry fetch buffer enabled by defining MEMARB_FETCH_BUF_EN.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          err,
    mem_port_arbiter_if.master mem
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] I_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;
    logic          can_issue;
    logic          expired;

`ifdef MEMARB_FETCH_BUF_EN
    logic          buf_valid_q, buf_valid_d;
    logic [AW-1:0] buf_tag_q, buf_tag_d;
    logic [DW-1:0] buf_data_q, buf_data_d;

    assign hit = buf_valid_q && (if_addr == buf_tag_q);

    // Fill on every fetch completion; a completed store to the buffered address invalidates it
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        if (state_q == I_WAIT && mem.mem_ack) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = mem_addr_q;
            buf_data_d  = mem.mem_rdata;
        end else if (state_q == D_WAIT && mem.mem_ack && mem_we_q && mem_addr_q == buf_tag_q) begin
            buf_valid_d = 1'b0;
        end
    end

    // Fetch buffer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // No new issue in a done cycle: the requester still shows the request it just had served
    assign can_issue = (state_q == IDLE) && !if_done_q && !d_done_q;
    assign expired   = cnt_q == CW'(TIMEOUT - 1);

    // Arbitration, wait/ack handling and timeout abort
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        if (can_issue && d_req) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            cnt_d       = '0;
            state_d     = D_WAIT;
        end else if (can_issue && if_req && hit) begin
`ifdef MEMARB_FETCH_BUF_EN
            if_rdata_d = buf_data_q;
`endif
            if_done_d  = 1'b1;
        end else if (can_issue && if_req) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            cnt_d      = '0;
            state_d    = I_WAIT;
        end else if (state_q != IDLE && (mem.mem_ack || expired)) begin
            mem_req_d = 1'b0;
            err_d     = err_q | ~mem.mem_ack;
            state_d   = IDLE;
            if (state_q == D_WAIT) begin
                d_done_d  = d_req;
                d_rdata_d = mem.mem_ack ? (mem_we_q ? d_rdata_q : mem.mem_rdata) : '0;
            end else begin
                if_done_d  = if_req;
                if_rdata_d = mem.mem_ack ? mem.mem_rdata : '0;
            end
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and registered outputs; async reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign if_done       = if_done_q;
    assign d_done        = d_done_q;
    assign err           = err_q;
    assign if_stall      = if_req & ~if_done_q;
    assign d_stall       = d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the fetch/data memory port arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata;
    logic        if_done, if_stall, d_done, d_stall, err;

    int          checks = 0, errors = 0;
    logic [31:0] if_q[$], d_q[$];
    int          order[$];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] d_hold = '0;
    int          ack_dly = 0, rcnt = 0;
    bit          ack_en = 1'b1;

`ifdef MEMARB_FETCH_BUF_EN
    localparam int HIT_REQ = 0, HIT_LAT = 1;
`else
    localparam int HIT_REQ = 1, HIT_LAT = 2;
`endif

    mem_port_arbiter_if #(.AW(32), .DW(32)) mem ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall), .err(err), .mem(mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : w(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory model: acks after ack_dly extra cycles of mem_req, writes stores on ack
    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            rcnt = mem.mem_req ? rcnt + 1 : 0;
            mem.mem_ack = ack_en && mem.mem_req && rcnt > ack_dly;
            mem.mem_rdata = mem.mem_ack ? rd(mem.mem_addr) : '0;
            if (mem.mem_ack && mem.mem_we) mem_arr[mem.mem_addr] = mem.mem_wdata;
        end
    end

    // Scoreboard: every completion pulse must match the oldest expectation
    initial forever begin
        smp();
        if (reset) begin
            if (if_done) begin
                if (if_q.size() == 0) chk("if_unexpected_done", 1, 0);
                else chk("if_rdata", if_rdata, if_q.pop_front());
                order.push_back(2);
            end
            if (d_done) begin
                if (d_q.size() == 0) chk("d_unexpected_done", 1, 0);
                else chk("d_rdata", d_rdata, d_q.pop_front());
                order.push_back(1);
            end
        end
    end

    task automatic wait_done(input bit dsel, input int max, input string tag);
        int n;
        n = 0;
        while (!(dsel ? d_done : if_done) && n < max) begin
            smp();
            n++;
        end
        chk(tag, 32'(n < max), 1);
    endtask

    task automatic xfer(input string tag, input bit d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp, input int n_req, input int n_lat);
        int reqs, lat;
        reqs = 0;
        lat = 0;
        cyc();
        if (d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
            d_q.push_back(we ? d_hold : exp);
            if (!we) d_hold = exp;
        end else begin
            if_req = 1'b1; if_addr = addr;
            if_q.push_back(exp);
        end
        smp();
        while (!(d ? d_done : if_done) && lat < 60) begin
            cyc();
            smp();
            lat++;
            if (mem.mem_req) begin
                reqs++;
                chk({tag, "_addr"}, mem.mem_addr, addr);
                chk({tag, "_we"}, 32'(mem.mem_we), 32'(we));
                if (we) chk({tag, "_wdata"}, mem.mem_wdata, wd);
            end
        end
        chk({tag, "_lat"}, lat, n_lat);
        chk({tag, "_reqs"}, reqs, n_req);
        cyc();
        d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        smp();
        chk("rst_mem_req", 32'(mem.mem_req), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_addr", mem.mem_addr, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        cyc();
        reset = 1'b1;

        // Minimum-latency fetch of 0x00
        cyc();
        if_req = 1'b1; if_addr = 32'h0; if_q.push_back(w(32'h0));
        smp();
        chk("f0_stall_n", 32'(if_stall), 1);
        chk("f0_req_n", 32'(mem.mem_req), 0);
        cyc(); smp();
        chk("f0_req_n1", 32'(mem.mem_req), 1);
        chk("f0_addr_n1", mem.mem_addr, 0);
        chk("f0_stall_n1", 32'(if_stall), 1);
        cyc(); smp();
        chk("f0_done_n2", 32'(if_done), 1);
        chk("f0_stall_n2", 32'(if_stall), 0);
        chk("f0_req_n2", 32'(mem.mem_req), 0);
        cyc();
        if_req = 1'b0;

        // Simultaneous fetch and load: data goes first
        cyc();
        order.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h40;
        d_q.push_back(w(32'h100)); if_q.push_back(w(32'h40)); d_hold = w(32'h100);
        smp(); cyc(); smp();
        chk("arb_addr", mem.mem_addr, 32'h100);
        chk("arb_we", 32'(mem.mem_we), 0);
        wait_done(1'b1, 20, "arb_d_timeout");
        cyc();
        d_req = 1'b0;
        wait_done(1'b0, 20, "arb_i_timeout");
        cyc();
        if_req = 1'b0;
        chk("order_count", order.size(), 2);
        chk("order_first_data", order[0], 1);

        // Store with 3-cycle ack delay, then read it back
        ack_dly = 3;
        xfer("st200", 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h0, 4, 5);
        ack_dly = 0;
        xfer("ld200", 1'b1, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 1, 2);

        // Timeout: load with no ack aborts after 16 request cycles
        ack_en = 1'b0;
        xfer("tmo", 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 16, 17);
        ack_en = 1'b1;
        chk("tmo_err", 32'(err), 1);
        xfer("f8", 1'b0, 1'b0, 32'h8, 32'h0, w(32'h8), 1, 2);
        chk("err_sticky", 32'(err), 1);

        // Flush: load withdrawn during wait completes silently but captures data
        ack_dly = 2;
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        cyc();
        d_req = 1'b0;
        repeat (6) cyc();
        chk("flush_rdata", d_rdata, w(32'h500));
        d_hold = w(32'h500);
        ack_dly = 0;

        // Asynchronous reset in the middle of a data wait
        ack_en = 1'b0;
        cyc();
        d_req = 1'b1; d_addr = 32'h400;
        cyc(); cyc(); smp();
        chk("rst_pre_req", 32'(mem.mem_req), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_req", 32'(mem.mem_req), 0);
        cyc();
        d_req = 1'b0; ack_en = 1'b1;
        cyc();
        reset = 1'b1;
        d_hold = '0;
        smp();
        chk("rst_err_clear", 32'(err), 0);
        chk("rst_d_rdata_clear", d_rdata, 0);
        xfer("ld100", 1'b1, 1'b0, 32'h100, 32'h0, w(32'h100), 1, 2);

        // Refetch behaviour and store invalidation
        xfer("f4_miss", 1'b0, 1'b0, 32'h4, 32'h0, w(32'h4), 1, 2);
        xfer("f4_refetch", 1'b0, 1'b0, 32'h4, 32'h0, w(32'h4), HIT_REQ, HIT_LAT);
        xfer("st4", 1'b1, 1'b1, 32'h4, 32'hCAFE_0004, 32'h0, 1, 2);
        xfer("f4_after_st", 1'b0, 1'b0, 32'h4, 32'h0, 32'hCAFE_0004, 1, 2);

        repeat (3) cyc();
        chk("if_q_empty", if_q.size(), 0);
        chk("d_q_empty", d_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
